// File: rtl/psum_serializer.sv
// Partial-sum serializer: buffers up to two lane vectors and emits them one
// lane per Send handshake, lane 0 first, flagging the last lane of each vector.
module psum_serializer #(
  parameter int DataWidth = 32,
  parameter int Lanes     = 4,
  parameter int LaneWidth = 2
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       sclr,
  input  logic                       VecInValid,
  input  logic [DataWidth*Lanes-1:0] VecIn,
  output logic                       VecInRdy,
  output logic                       DataOutValid,
  input  logic                       DataOutRdy,
  output logic [DataWidth-1:0]       DataOut,
  output logic                       LastOut
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  localparam logic [LaneWidth-1:0] LastLane = LaneWidth'(Lanes - 1);

  occ_t                       occ;
  occ_t                       occ_next;
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [LaneWidth-1:0]       lane_cnt;
  logic [DataWidth*Lanes-1:0] mem [2];
  logic [DataWidth-1:0]       head_lanes [Lanes];

  logic rec;
  logic send;
  logic pop;

  assign rec  = VecInValid & VecInRdy;
  assign send = DataOutValid & DataOutRdy;
  assign pop  = send & (lane_cnt == LastLane);

  // Occupancy register and datapath state
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      occ      <= OCC_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      lane_cnt <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else if (sclr) begin
      occ      <= OCC_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      lane_cnt <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      occ <= occ_next;
      if (rec) begin
        mem[wr_ptr] <= VecIn;
        wr_ptr      <= ~wr_ptr;
      end
      if (send) begin
        if (pop) begin
          lane_cnt <= '0;
          rd_ptr   <= ~rd_ptr;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
        end
      end
    end
  end

  // A push and a pop in the same cycle leave occupancy unchanged.
  always_comb begin
    occ_next = occ;
    unique case (occ)
      OCC_EMPTY: if (rec) occ_next = OCC_ONE;
      OCC_ONE: begin
        if (rec && !pop)      occ_next = OCC_FULL;
        else if (!rec && pop) occ_next = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_next = OCC_ONE;
      default:   occ_next = OCC_EMPTY;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < Lanes; i++) begin
      head_lanes[i] = mem[rd_ptr][i*DataWidth +: DataWidth];
    end
  end

  always_comb begin
    VecInRdy     = (occ != OCC_FULL);
    DataOutValid = (occ != OCC_EMPTY);
    DataOut      = head_lanes[lane_cnt];
    LastOut      = DataOutValid & (lane_cnt == LastLane);
  end

endmodule

// File: tb/tb_psum_serializer.sv
// Randomized and directed bench for psum_serializer against a queue-based
// model of the vector FIFO and lane ordering.
module tb_psum_serializer;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int LW = 2;
  localparam int VW = DW * LN;

  logic          clk = 1'b0;
  logic          aclr;
  logic          sclr;
  logic          VecInValid;
  logic [VW-1:0] VecIn;
  logic          VecInRdy;
  logic          DataOutValid;
  logic          DataOutRdy;
  logic [DW-1:0] DataOut;
  logic          LastOut;

  psum_serializer #(.DataWidth(DW), .Lanes(LN), .LaneWidth(LW)) dut (
    .clk         (clk),
    .aclr        (aclr),
    .sclr        (sclr),
    .VecInValid  (VecInValid),
    .VecIn       (VecIn),
    .VecInRdy    (VecInRdy),
    .DataOutValid(DataOutValid),
    .DataOutRdy  (DataOutRdy),
    .DataOut     (DataOut),
    .LastOut     (LastOut)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [VW-1:0] mq[$];
  int            m_lane  = 0;
  bit            m_fresh = 1;
  int            n_acc   = 0;
  int            dut_sends = 0;
  int            dut_lasts = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_lane  = 0;
    m_fresh = 1;
  endtask

  // Check outputs against the model, then advance one clock and update it.
  task automatic step();
    logic [VW-1:0] head;
    logic [VW-1:0] vin;
    bit rec, send;
    chk("rdy", VecInRdy, (mq.size() < 2));
    chk("valid", DataOutValid, (mq.size() != 0));
    if (mq.size() != 0) begin
      head = mq[0];
      chk("data", DataOut, head[m_lane*DW +: DW]);
      chk("last", LastOut, (m_lane == LN - 1));
    end else begin
      chk("last_idle", LastOut, 0);
      if (m_fresh) chk("data_rst", DataOut, 0);
    end
    if (DataOutValid && DataOutRdy) begin
      dut_sends++;
      if (LastOut) dut_lasts++;
    end
    rec  = VecInValid && (mq.size() < 2);
    send = (mq.size() != 0) && DataOutRdy;
    vin  = VecIn;
    @(posedge clk);
    #1;
    if (sclr) begin
      model_clear();
    end else begin
      if (send) begin
        if (m_lane == LN - 1) begin
          void'(mq.pop_front());
          m_lane = 0;
        end else begin
          m_lane++;
        end
      end
      if (rec) begin
        mq.push_back(vin);
        m_fresh = 0;
        n_acc++;
      end
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  initial begin
    int budget;
    aclr = 1'b1; sclr = 1'b0; VecInValid = 1'b0; VecIn = '0; DataOutRdy = 1'b0;
    #12;
    chk("rst_rdy", VecInRdy, 1);
    chk("rst_valid", DataOutValid, 0);
    chk("rst_last", LastOut, 0);
    chk("rst_data", DataOut, 0);
    @(negedge clk); aclr = 1'b0;
    @(posedge clk); #1;

    // Single vector, lanes 0x10..0x40
    DataOutRdy = 1'b1;
    VecInValid = 1'b1; VecIn = {32'h40, 32'h30, 32'h20, 32'h10};
    step();
    VecInValid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Three vectors back-to-back with the sink always ready
    dut_sends = 0;
    for (int v = 0; v < 3; v++) begin
      VecInValid = 1'b1; VecIn = rand_vec();
      budget = 0;
      do begin
        bit take;
        take = (mq.size() < 2);
        step();
        budget++;
        if (take) break;
      end while (budget < 10);
    end
    VecInValid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("b2b_sends", dut_sends, 3 * LN);

    // Backpressure: sink stalled, three vectors offered
    DataOutRdy = 1'b0;
    for (int v = 0; v < 3; v++) begin
      VecInValid = 1'b1; VecIn = rand_vec();
      if (v < 2) step();
    end
    for (int i = 0; i < 3; i++) step();
    chk("bp_held_rdy", VecInRdy, 0);
    DataOutRdy = 1'b1;
    for (int i = 0; i < LN; i++) step();
    step();
    VecInValid = 1'b0;
    for (int i = 0; i < 3 * LN; i++) step();

    // sclr after lane 1 with a second vector queued
    VecInValid = 1'b1; VecIn = rand_vec(); step();
    VecIn = rand_vec(); step();
    VecInValid = 1'b0; step();
    sclr = 1'b1; VecInValid = 1'b1; VecIn = rand_vec(); step();
    sclr = 1'b0; VecInValid = 1'b0;
    chk("sclr_valid", DataOutValid, 0);
    chk("sclr_rdy", VecInRdy, 1);
    VecInValid = 1'b1; VecIn = rand_vec(); step();
    VecInValid = 1'b0;
    for (int i = 0; i < LN + 1; i++) step();

    // Randomized traffic: 200 vectors, 50% valid and 50% ready
    n_acc = 0; dut_sends = 0; dut_lasts = 0;
    budget = 0;
    while ((n_acc < 200 || mq.size() != 0) && budget < 5000) begin
      VecInValid = (n_acc < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      VecIn      = rand_vec();
      DataOutRdy = 1'($urandom_range(0, 1));
      step();
      budget++;
    end
    VecInValid = 1'b0;
    chk("rand_budget", (budget < 5000), 1);
    chk("rand_sends", dut_sends, 200 * LN);
    chk("rand_lasts", dut_lasts, 200);

    // Asynchronous clear between edges while data is in flight
    DataOutRdy = 1'b0;
    VecInValid = 1'b1; VecIn = rand_vec(); step();
    VecIn = rand_vec(); step();
    VecInValid = 1'b0;
    #2 aclr = 1'b1;
    #1;
    chk("aclr_valid", DataOutValid, 0);
    chk("aclr_last", LastOut, 0);
    chk("aclr_data", DataOut, 0);
    chk("aclr_rdy", VecInRdy, 1);
    model_clear();
    #1 aclr = 1'b0;
    @(posedge clk); #1;
    DataOutRdy = 1'b1;
    VecInValid = 1'b1; VecIn = rand_vec(); step();
    VecInValid = 1'b0;
    for (int i = 0; i < LN + 1; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
